// File: rtl/sample_reorder_buffer_pkg.sv
// sample_reorder_buffer_pkg: shared FSM state type and default geometry for the sample reorder buffer.
package sample_reorder_buffer_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_LOG2_N = 3;
  typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_e;
endpackage

// File: rtl/bit_reverse.sv
// bit_reverse: combinational reversal of a WIDTH-bit index.
//   a_i : index to reverse
//   y_o : a_i with bit order reversed (bit 0 <-> bit WIDTH-1)
module bit_reverse #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH-1:0] y_o
);
  for (genvar g = 0; g < WIDTH; g++) begin : g_rev
    assign y_o[g] = a_i[WIDTH-1-g];
  end
endmodule

// File: rtl/sample_reorder_buffer.sv
// sample_reorder_buffer: collects a frame of N samples in bit-reversed slots, then streams them out in slot order.
//   clk       : single clock, all state updates on posedge
//   clr_n     : asynchronous active-low reset (clears FSM, counters, frame count and storage)
//   abort     : synchronous frame abort, blocks handshakes and restarts filling
//   in_valid  / in_ready  / in_data            : upstream sample stream (accepted only while filling)
//   out_valid / out_ready / out_data / out_last : reordered stream, out_last marks slot N-1
//   frame_cnt : number of fully drained frames, wraps at 256
module sample_reorder_buffer
  import sample_reorder_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LOG2_N = DEF_LOG2_N
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  abort,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [7:0]            frame_cnt
);
  localparam int N = 1 << LOG2_N;
  localparam logic [LOG2_N-1:0] LAST = '1;
  state_e state_q, state_d;
  logic [LOG2_N-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, wr_addr;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [N];
  logic in_hs, out_hs, fill_done, frame_done;
  bit_reverse #(.WIDTH(LOG2_N)) u_rev (.a_i(wr_cnt_q), .y_o(wr_addr));
  assign in_hs = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;
  assign fill_done = in_hs & (wr_cnt_q == LAST);
  assign frame_done = out_hs & (rd_cnt_q == LAST);
  assign frame_cnt = frame_cnt_q;
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= FILL;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end
  // Counters wrap naturally at N; abort rewinds both without touching storage or frame count.
  always_comb begin
    state_d = abort ? FILL : fill_done ? DRAIN : frame_done ? FILL : state_q;
    wr_cnt_d = abort ? '0 : wr_cnt_q + LOG2_N'(in_hs);
    rd_cnt_d = abort ? '0 : rd_cnt_q + LOG2_N'(out_hs);
    frame_cnt_d = frame_cnt_q + 8'(frame_done);
  end
  always_comb begin
    in_ready = (state_q == FILL) & ~abort;
    out_valid = (state_q == DRAIN) & ~abort;
    out_data = mem_q[rd_cnt_q];
    out_last = out_valid & (rd_cnt_q == LAST);
  end
  for (genvar g = 0; g < N; g++) begin : g_mem
    always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) mem_q[g] <= '0;
      else if (in_hs && wr_addr == LOG2_N'(g)) mem_q[g] <= in_data;
    end
  end
endmodule

// File: tb/tb_sample_reorder_buffer.sv
// tb_sample_reorder_buffer: scoreboard bench for sample_reorder_buffer (N = 8).
module tb_sample_reorder_buffer;
  typedef struct {logic [31:0] d; logic last;} exp_t;
  logic clk = 1'b0;
  logic clr_n, abort, in_valid, in_ready, out_valid, out_ready, out_last;
  logic [31:0] in_data, out_data;
  logic [7:0] frame_cnt;
  int checks = 0;
  int failures = 0;
  exp_t sb[$];
  logic [31:0] got[$];
  logic m_fill;
  int m_wr;
  logic [7:0] m_frames;
  logic [31:0] m_buf [8];
  logic [31:0] exp_ord [8];
  logic [31:0] ctr;

  sample_reorder_buffer dut (
    .clk(clk), .clr_n(clr_n), .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] rev3(input logic [2:0] k);
    return {k[0], k[1], k[2]};
  endfunction

  task automatic mdl_reset();
    sb.delete();
    got.delete();
    m_fill = 1'b1;
    m_wr = 0;
    m_frames = 8'd0;
  endtask

  // One clock: sample DUT at negedge against the model, advance the model, return #1 after posedge.
  task automatic tick();
    logic m_in, m_out;
    exp_t e;
    @(negedge clk);
    m_in = m_fill & ~abort;
    m_out = ~m_fill & ~abort;
    checks++;
    if (in_ready !== m_in) begin
      failures++;
      $display("FAIL in_ready: got %b expected %b at %0t", in_ready, m_in, $time);
    end
    checks++;
    if (out_valid !== m_out) begin
      failures++;
      $display("FAIL out_valid: got %b expected %b at %0t", out_valid, m_out, $time);
    end
    if (m_out) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL scoreboard: output expected but queue empty at %0t", $time);
      end else if (out_data !== sb[0].d || out_last !== sb[0].last) begin
        failures++;
        $display("FAIL out_data/last: got %h/%b expected %h/%b at %0t", out_data, out_last, sb[0].d, sb[0].last, $time);
      end
    end else begin
      checks++;
      if (out_last !== 1'b0) begin
        failures++;
        $display("FAIL out_last_idle: got %b expected 0 at %0t", out_last, $time);
      end
    end
    if (abort) begin
      m_fill = 1'b1;
      m_wr = 0;
      sb.delete();
    end else if (m_in && in_valid) begin
      m_buf[m_wr] = in_data;
      m_wr++;
      if (m_wr == 8) begin
        for (int j = 0; j < 8; j++) sb.push_back('{m_buf[rev3(3'(j))], j == 7});
        m_wr = 0;
        m_fill = 1'b0;
      end
    end else if (m_out && out_ready && sb.size() > 0) begin
      e = sb.pop_front();
      got.push_back(e.d);
      if (e.last) begin
        m_fill = 1'b1;
        m_frames++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [31:0] base);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data = base + 32'(i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic do_reset();
    clr_n = 1'b0;
    #1;
    mdl_reset();
    @(posedge clk);
    #1;
    clr_n = 1'b1;
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    abort = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = 32'd0;
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 32'd0 || frame_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b l=%b d=%h fc=%0d expected 0/0/0/0", out_valid, out_last, out_data, frame_cnt);
    end
    mdl_reset();
    @(posedge clk);
    #1;
    clr_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_basic();
    exp_ord = '{32'd0, 32'd4, 32'd2, 32'd6, 32'd1, 32'd5, 32'd3, 32'd7};
    got.delete();
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = (i < 8) ? 32'(i) : 32'd99;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (got.size() != 8) begin
      failures++;
      $display("FAIL basic_count: got %0d outputs expected 8", got.size());
    end else
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (got[i] !== exp_ord[i]) begin
          failures++;
          $display("FAIL basic_order[%0d]: got %h expected %h", i, got[i], exp_ord[i]);
        end
      end
    checks++;
    if (frame_cnt !== 8'd1) begin
      failures++;
      $display("FAIL basic_frame_cnt: got %0d expected 1", frame_cnt);
    end
  endtask

  task automatic test_backpressure();
    exp_ord = '{32'd0, 32'd4, 32'd2, 32'd6, 32'd1, 32'd5, 32'd3, 32'd7};
    got.delete();
    feed(32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_data !== 32'd4 || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%h expected v=1 d=4", i, out_valid, out_data);
      end
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (got.size() != 8 || got[1] !== 32'd4 || got[7] !== 32'd7) begin
      failures++;
      $display("FAIL bp_order: got n=%0d expected 8 with [1]=4 [7]=7", got.size());
    end
    checks++;
    if (frame_cnt !== 8'd2) begin
      failures++;
      $display("FAIL bp_frame_cnt: got %0d expected 2", frame_cnt);
    end
  endtask

  task automatic test_ignore_during_drain();
    got.delete();
    feed(32'h100);
    in_valid = 1'b1;
    in_data = 32'hDEAD;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) out_ready = 1'b1;
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL drain_in_ready: got %b expected 0", in_ready);
      end
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    feed(32'h200);
    drain();
    checks++;
    if (got.size() != 16 || got[8] !== 32'h200 || got[9] !== 32'h204 || got[15] !== 32'h207) begin
      failures++;
      $display("FAIL drain_ignore_next: got n=%0d expected 16 with 200,204..207", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] === 32'hDEAD) begin
        failures++;
        $display("FAIL drain_ignore_leak[%0d]: got %h expected not DEAD", i, got[i]);
      end
    end
  endtask

  task automatic test_abort();
    logic [7:0] fc_before;
    exp_ord = '{32'd10, 32'd14, 32'd12, 32'd16, 32'd11, 32'd15, 32'd13, 32'd17};
    got.delete();
    fc_before = frame_cnt;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data = 32'h300 + 32'(i);
      tick();
    end
    abort = 1'b1;
    in_data = 32'hBAD;
    tick();
    abort = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (frame_cnt !== fc_before) begin
      failures++;
      $display("FAIL abort_frame_cnt: got %0d expected %0d", frame_cnt, fc_before);
    end
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data = 32'd10 + 32'(i);
      tick();
    end
    in_valid = 1'b0;
    drain();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== exp_ord[i]) begin
        failures++;
        $display("FAIL abort_order[%0d]: got %h expected %h", i, (i < got.size()) ? got[i] : 32'hX, exp_ord[i]);
      end
    end
    checks++;
    if (frame_cnt !== fc_before + 8'd1) begin
      failures++;
      $display("FAIL abort_frame_cnt_after: got %0d expected %0d", frame_cnt, fc_before + 8'd1);
    end
  endtask

  task automatic test_reset_mid_frame();
    feed(32'd20);
    out_ready = 1'b1;
    tick();
    tick();
    clr_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 32'd0 || frame_cnt !== 8'd0) begin
      failures++;
      $display("FAIL midreset_outputs: got v=%b l=%b d=%h fc=%0d expected 0/0/0/0", out_valid, out_last, out_data, frame_cnt);
    end
    mdl_reset();
    @(posedge clk);
    #1;
    clr_n = 1'b1;
    exp_ord = '{32'd30, 32'd34, 32'd32, 32'd36, 32'd31, 32'd35, 32'd33, 32'd37};
    feed(32'd30);
    drain();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== exp_ord[i]) begin
        failures++;
        $display("FAIL midreset_order[%0d]: got %h expected %h", i, (i < got.size()) ? got[i] : 32'hX, exp_ord[i]);
      end
    end
    checks++;
    if (frame_cnt !== 8'd1) begin
      failures++;
      $display("FAIL midreset_frame_cnt: got %0d expected 1", frame_cnt);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ctr = 32'd0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int f = 0; f < 256; f++) begin
      for (int c = 0; c < 16; c++) begin
        in_data = ctr;
        ctr++;
        tick();
      end
      got.delete();
      if (f == 254) begin
        checks++;
        if (frame_cnt !== 8'd255) begin
          failures++;
          $display("FAIL b2b_frame_cnt_255: got %0d expected 255", frame_cnt);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (frame_cnt !== 8'd0) begin
      failures++;
      $display("FAIL b2b_frame_cnt_wrap: got %0d expected 0", frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_ignore_during_drain();
    test_abort();
    test_reset_mid_frame();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sample_reorder_buffer.md
SAMPLE_REORDER_BUFFER -- requirements
Module: sample_reorder_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning width of one sample word (packed complex: [31:16] real, [15:0] imag).
REQ-002 SHALL have parameter LOG2_N, default 3, meaning log2 of frame length N (N = 8 by default, legal range 1..10).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port clr_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port abort  input  1  synchronous frame abort.
REQ-006 SHALL have port in_valid  input  1  upstream sample valid.
REQ-007 SHALL have port in_ready  output  1  buffer accepts a sample.
REQ-008 SHALL have port in_data  input  DATA_WIDTH  upstream sample.
REQ-009 SHALL have port out_valid  output  1  reordered sample valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts a sample.
REQ-011 SHALL have port out_data  output  DATA_WIDTH  reordered sample.
REQ-012 SHALL have port out_last  output  1  high with the final sample (index N-1) of a frame.
REQ-013 SHALL have port frame_cnt  output  8  count of fully drained frames, wraps 255 -> 0.

Function
REQ-014 SHALL hold N storage entries of DATA_WIDTH bits, a LOG2_N-bit write counter wr_cnt and a LOG2_N-bit read counter rd_cnt.
REQ-015 SHALL implement a two-state FSM: FILL and DRAIN; single buffer, no fill/drain overlap.
REQ-016 FILL: in_ready = ~abort, out_valid = 0.
REQ-017 FILL: on in_valid & in_ready, entry[bitrev(wr_cnt)] <= in_data, wr_cnt <= wr_cnt + 1.
REQ-018 FILL: acceptance with wr_cnt == N-1 SHALL wrap wr_cnt to 0 and move to DRAIN next cycle.
REQ-019 DRAIN: in_ready = 0, out_valid = ~abort, out_data = entry[rd_cnt] (combinational from storage), out_last = (rd_cnt == N-1) & out_valid.
REQ-020 DRAIN: on out_valid & out_ready, rd_cnt <= rd_cnt + 1; if rd_cnt == N-1, rd_cnt wraps to 0, frame_cnt increments, FSM returns to FILL.
REQ-021 Latency: first out_valid in the cycle after the Nth input handshake; first in_ready in the cycle after the out_last handshake.
REQ-022 out_data and out_last SHALL stay stable while out_valid & ~out_ready (backpressure of any length).
REQ-023 in_valid while in_ready = 0 SHALL be ignored, no storage write.
REQ-024 abort high in any state: no handshake completes that cycle; next cycle FSM = FILL, wr_cnt = rd_cnt = 0; storage and frame_cnt unchanged.
REQ-025 bitrev(k) SHALL reverse the LOG2_N bits of k (N=8: 0,4,2,6,1,5,3,7 for k = 0..7).

Reset
REQ-026 clr_n low SHALL immediately and asynchronously set FSM = FILL, wr_cnt = 0, rd_cnt = 0, frame_cnt = 0, all storage entries = 0.
REQ-027 During reset outputs SHALL be in_ready = 1 as soon as clr_n is high (FILL state), out_valid = 0, out_last = 0, out_data = 0.
REQ-028 Reset mid-frame SHALL discard the partial frame; no output of stale samples after release.

Structure
REQ-029 Shared package SHALL hold the FSM state typedef (FILL, DRAIN) and default DATA_WIDTH/LOG2_N constants.
REQ-030 One sub-module, bit_reverse (parameter WIDTH, combinational), SHALL compute the write address.
REQ-031 Storage SHALL be built from per-entry write-enabled registers with async clear driven from clr_n.

Verification
REQ-032 Reset, feed 0..7 with in_valid always 1, out_ready always 1 -> out_data 0,4,2,6,1,5,3,7; out_last only on 7; frame_cnt = 1.
REQ-033 Frame of 8 inputs, out_ready low 5 cycles after 2nd output -> out_data holds 4 for those cycles, order unchanged, no loss.
REQ-034 Assert in_valid with data 0xDEAD during DRAIN -> in_ready = 0, sample not stored, next frame output unaffected.
REQ-035 Abort after 5 inputs, then feed 10..17 -> outputs 10,14,12,16,11,15,13,17; frame_cnt unchanged by abort.
REQ-036 Pull clr_n low at 3rd output of a frame -> out_valid = 0 immediately, frame_cnt = 0, next frame drains correctly from FILL.
REQ-037 Drain 256 back-to-back frames -> frame_cnt wraps to 0, in_ready returns exactly 1 cycle after each out_last handshake.
